// File: rtl/tt_stream_pkg.sv
// rtl/tt_stream_pkg.sv - shared types and constants for the TT byte-stream front end
package tt_stream_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_UNITS = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // ceil(log2(n)) but never below 1, so single-entry fields still get one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_strobe_sync.sv
// rtl/stream_strobe_sync.sv - 2-FF pin synchroniser with rising-edge strobe and matched data delay
module stream_strobe_sync
  import tt_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_valid,
  input  logic [BYTE_W-1:0] pin_byte,
  output logic              stb,
  output logic [BYTE_W-1:0] byte_out
);

  logic              v_meta, v_sync, v_prev;
  logic [BYTE_W-1:0] d_meta, d_sync;

  // strobe and data travel through the same two stages so the byte lines up with its strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_meta <= 1'b0;
      v_sync <= 1'b0;
      v_prev <= 1'b0;
      d_meta <= '0;
      d_sync <= '0;
    end else begin
      v_meta <= pin_valid;
      v_sync <= v_meta;
      v_prev <= v_sync;
      d_meta <= pin_byte;
      d_sync <= d_meta;
    end
  end

  assign stb      = v_sync & ~v_prev;
  assign byte_out = d_sync;

endmodule

// File: rtl/sample_stream_deframer.sv
// rtl/sample_stream_deframer.sv - assembles MSB-first byte stream into channel-tagged samples
module sample_stream_deframer
  import tt_stream_pkg::*;
#(
  parameter int NUM_UNITS      = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_INPUTS    = 1,
  localparam int CH_W          = clog2_min1(NUM_UNITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_valid,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  auto_mode,
  input  logic                  resync,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic [CH_W-1:0]       sample_ch,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BYTES  = DATA_WIDTH / BYTE_W;
  localparam int CNT_W  = clog2_min1(BYTES + 1);
  localparam int IDLE_W = clog2_min1(TIMEOUT_CYCLES);

  logic              stb;
  logic [BYTE_W-1:0] byte_s;

  generate
    if (SYNC_INPUTS != 0) begin : g_sync
      stream_strobe_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .pin_valid(byte_valid),
        .pin_byte (byte_in),
        .stb      (stb),
        .byte_out (byte_s)
      );
    end else begin : g_direct
      assign stb    = byte_valid;
      assign byte_s = byte_in;
    end
  endgenerate

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDLE_W-1:0]     idle, idle_n;
  logic [DATA_WIDTH-1:0] shift, shift_n, base;
  logic [CH_W-1:0]       ch_lat, ch_lat_n, rr;
  logic                  complete, timeout, bad_ch, room, accept, drop;

  // next-state: byte assembly, idle timeout and completion detection
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idle_n   = idle;
    shift_n  = shift;
    ch_lat_n = ch_lat;
    complete = 1'b0;
    timeout  = 1'b0;
    base     = (state == IDLE) ? '0 : shift;
    if (resync) begin
      state_n = IDLE;
      cnt_n   = '0;
      idle_n  = '0;
    end else if (stb) begin
      shift_n = (base << BYTE_W) | DATA_WIDTH'(byte_s);
      idle_n  = '0;
      if (state == IDLE) begin
        ch_lat_n = auto_mode ? rr : ch_sel;
        if (BYTES == 1) begin
          complete = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n   = CNT_W'(1);
          state_n = COLLECT;
        end
      end else if (cnt == CNT_W'(BYTES - 1)) begin
        complete = 1'b1;
        cnt_n    = '0;
        state_n  = IDLE;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end else if (state == COLLECT) begin
      if (idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
        idle_n  = '0;
      end else begin
        idle_n = idle + IDLE_W'(1);
      end
    end
    bad_ch = int'(ch_lat_n) >= NUM_UNITS;
    room   = !sample_valid || sample_ready;
    accept = complete && !bad_ch && room;
    drop   = complete && !bad_ch && !room;
  end

  // FSM and assembly registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idle   <= '0;
      shift  <= '0;
      ch_lat <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idle   <= idle_n;
      shift  <= shift_n;
      ch_lat <= ch_lat_n;
    end
  end

  // round-robin pointer moves only when a sample was delivered or lost to overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else if (resync) begin
      rr <= '0;
    end else if (accept || drop) begin
      rr <= (rr == CH_W'(NUM_UNITS - 1)) ? '0 : rr + CH_W'(1);
    end
  end

  // one-deep output register with same-cycle drain/refill, sticky overflow and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= timeout || (complete && bad_ch);
      if (drop) overflow <= 1'b1;
      if (accept) begin
        sample_data  <= shift_n;
        sample_ch    <= ch_lat_n;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_sample_stream_deframer.sv
// tb/tb_sample_stream_deframer.sv - directed self-checking bench for sample_stream_deframer
module tb_sample_stream_deframer;

  logic clk, rst;

  // instance A: synchronous strobe, 16-bit samples, three channels
  logic [7:0]  a_byte;
  logic        a_valid, a_auto, a_resync, a_ready;
  logic [1:0]  a_ch_sel, a_ch;
  logic [15:0] a_data;
  logic        a_svalid, a_ovf, a_ferr, a_busy;

  // instance B: pin-synchronised strobe, 24-bit samples, two channels
  logic [7:0]  b_byte;
  logic        b_valid, b_auto, b_resync, b_ready;
  logic        b_ch_sel, b_ch;
  logic [23:0] b_data;
  logic        b_svalid, b_ovf, b_ferr, b_busy;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  sample_stream_deframer #(
    .NUM_UNITS(3), .DATA_WIDTH(16), .TIMEOUT_CYCLES(64), .SYNC_INPUTS(0)
  ) u_a (
    .clk(clk), .rst(rst), .byte_in(a_byte), .byte_valid(a_valid), .ch_sel(a_ch_sel),
    .auto_mode(a_auto), .resync(a_resync), .sample_data(a_data), .sample_ch(a_ch),
    .sample_valid(a_svalid), .sample_ready(a_ready), .overflow(a_ovf),
    .frame_err(a_ferr), .busy(a_busy)
  );

  sample_stream_deframer #(
    .NUM_UNITS(2), .DATA_WIDTH(24), .TIMEOUT_CYCLES(64), .SYNC_INPUTS(1)
  ) u_b (
    .clk(clk), .rst(rst), .byte_in(b_byte), .byte_valid(b_valid), .ch_sel(b_ch_sel),
    .auto_mode(b_auto), .resync(b_resync), .sample_data(b_data), .sample_ch(b_ch),
    .sample_valid(b_svalid), .sample_ready(b_ready), .overflow(b_ovf),
    .frame_err(b_ferr), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] b);
    a_byte  = b;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask

  // hold the pin high for two clocks then low for two, like a slow external master
  task automatic b_send(input logic [7:0] b);
    b_byte  = b;
    b_valid = 1'b1;
    tick();
    tick();
    b_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_byte = 8'h00; a_valid = 1'b0; a_auto = 1'b0; a_resync = 1'b0; a_ready = 1'b1; a_ch_sel = 2'd1;
    b_byte = 8'h00; b_valid = 1'b0; b_auto = 1'b1; b_resync = 1'b0; b_ready = 1'b0; b_ch_sel = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_a_valid", a_svalid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_ferr", a_ferr, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_valid", b_svalid, 0);
    rst = 1'b0;
    tick();

    // manual channel, two bytes, one-cycle output
    a_send(8'h12);
    chk("t1_busy", a_busy, 1);
    chk("t1_early_valid", a_svalid, 0);
    a_send(8'h34);
    chk("t1_valid", a_svalid, 1);
    chk("t1_data", a_data, 16'h1234);
    chk("t1_ch", a_ch, 1);
    chk("t1_ovf", a_ovf, 0);
    chk("t1_busy_done", a_busy, 0);
    tick();
    chk("t1_valid_drop", a_svalid, 0);

    // round-robin tagging after a resync clears the pointer
    a_resync = 1'b1;
    tick();
    a_resync = 1'b0;
    a_auto = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      a_send(8'h00);
      a_send(8'(i));
      chk($sformatf("t2_data%0d", i), a_data, 32'(i));
      chk($sformatf("t2_ch%0d", i), a_ch, 32'((i - 1) % 3));
    end
    tick();

    // partial sample timeout
    a_send(8'hAB);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (a_ferr) begin
        n = i;
        break;
      end
    end
    chk("t3_timeout_cycles", n, 64);
    chk("t3_busy_fell", a_busy, 0);
    tick();
    chk("t3_ferr_pulse", a_ferr, 0);
    a_send(8'h00);
    a_send(8'h05);
    chk("t3_data", a_data, 16'h0005);
    chk("t3_ch", a_ch, 0);
    tick();

    // consumer stalled: second sample overflows, pointer still advances
    a_ready = 1'b0;
    a_send(8'h11);
    a_send(8'h11);
    chk("t4_first_ch", a_ch, 1);
    a_send(8'h22);
    a_send(8'h22);
    chk("t4_hold_valid", a_svalid, 1);
    chk("t4_hold_data", a_data, 16'h1111);
    chk("t4_ovf", a_ovf, 1);
    a_ready = 1'b1;
    tick();
    chk("t4_drained", a_svalid, 0);
    a_send(8'h33);
    a_send(8'h33);
    chk("t4_next_data", a_data, 16'h3333);
    chk("t4_next_ch", a_ch, 0);
    chk("t4_ovf_sticky", a_ovf, 1);

    // out-of-range manual channel
    a_auto = 1'b0;
    a_ch_sel = 2'd3;
    a_send(8'h44);
    a_send(8'h44);
    chk("t4b_ferr", a_ferr, 1);
    chk("t4b_no_valid", a_svalid, 0);
    a_ch_sel = 2'd1;

    // pin-synchronised 24-bit stream
    b_ready = 1'b1;
    n = 0;
    b_send(8'hDE);
    b_send(8'hAD);
    chk("t5_no_early", b_svalid, 0);
    b_byte = 8'hBE;
    b_valid = 1'b1;
    tick();
    chk("t5_lat1", b_svalid, 0);
    tick();
    b_valid = 1'b0;
    chk("t5_lat2", b_svalid, 0);
    tick();
    chk("t5_lat3_valid", b_svalid, 1);
    chk("t5_data", b_data, 24'hDEADBE);
    chk("t5_ch", b_ch, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b_svalid) n++;
    end
    chk("t5_single_sample", n, 0);

    // asynchronous reset mid-sample
    a_auto = 1'b1;
    a_send(8'h55);
    chk("t6_busy", a_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_ovf", a_ovf, 0);
    chk("t6_rst_data", a_data, 0);
    chk("t6_rst_ch", a_ch, 0);
    tick();
    rst = 1'b0;
    tick();

    // resync beats a simultaneous strobe
    a_byte = 8'h77;
    a_valid = 1'b1;
    a_resync = 1'b1;
    tick();
    a_valid = 1'b0;
    a_resync = 1'b0;
    chk("t6_resync_busy", a_busy, 0);
    a_send(8'h12);
    a_send(8'h34);
    chk("t6_data", a_data, 16'h1234);
    chk("t6_ch", a_ch, 0);
    chk("t6_valid", a_svalid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
